add_rs_sched: RTL and testbench
===============================

Name: add_rs_sched

Overview:
- Issue scheduler for the add/sub reservation stations and the single add/sub execution unit in the Tomasulo core.
- Accepts dispatched add/sub ops into RS_DEPTH entries and snoops the CDB to wake pending operands.
- Picks the oldest entry with both operands ready and drives the exec unit's issue strobe and operand bus.
- Times the exec latency, then frees the entry and decrements occupancy.

Parameters:
- RS_DEPTH, 3, number of reservation-station entries.
- DATA_W, 8, operand width.
- TAG_W, 3, ROB-index/tag width.
- EX_LAT, 1, exec-unit cycles from issue to result; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- alloc_valid  in  1  dispatch presents an add/sub op.
- alloc_ready  out  1  a free entry exists.
- alloc_func  in  4  0000 add, 0001 sub.
- alloc_rd  in  4  destination register.
- alloc_rob  in  TAG_W  ROB index of the op.
- alloc_src1_rdy / alloc_src2_rdy  in  1  operand already valid.
- alloc_src1_tag / alloc_src2_tag  in  TAG_W  producer ROB tag when not ready.
- alloc_src1_data / alloc_src2_data  in  DATA_W  operand value when ready.
- cdb_valid  in  1  result broadcast.
- cdb_tag  in  TAG_W  producer ROB tag of the broadcast.
- cdb_data  in  DATA_W  broadcast value.
- ex_b  out  1  one-cycle issue strobe to the exec unit.
- ex_rs_index  out  TAG_W  issuing entry index.
- ex_rs1_data / ex_rs2_data  out  DATA_W  operands.
- ex_func  out  4  operation.
- ex_rd  out  4  destination register.
- ex_rob_ind  out  TAG_W  ROB index.
- ex_busy  out  1  exec unit occupied.
- add_count  out  TAG_W  valid-entry count.

Behaviour:
- Reset (async): all entries invalid, FSM=IDLE, every output 0 except alloc_ready=1. Reset mid-operation discards in-flight and queued ops, with no completion pulse.
- Entry fields: valid, func, rd, rob, rdy1, tag1, d1, rdy2, tag2, d2, age, issued.
- Allocation:
  - alloc_ready = (add_count < RS_DEPTH), evaluated on registered state.
  - On alloc_valid && alloc_ready, the lowest-index free entry is written and age = add_count.
- Wakeup:
  - Each cycle with cdb_valid, every valid entry with rdyN=0 and tagN==cdb_tag sets rdyN=1 and dN=cdb_data.
  - The entry being allocated in the same cycle also snoops: an alloc tag matching cdb_tag is captured as ready.
- Selection:
  - An entry is eligible when valid && rdy1 && rdy2 && !issued, using start-of-cycle state. An entry woken this cycle is eligible next cycle.
  - Among eligible entries the smallest age wins; ties are impossible.
- FSM:
  - IDLE -> ISSUE when an eligible entry exists.
  - ISSUE (1 cycle): ex_b=1, ex_* registered from the winner, entry.issued=1, ex_busy=1, lat_cnt=EX_LAT.
  - ISSUE -> WAIT. WAIT decrements lat_cnt each cycle.
  - When lat_cnt==1: entry freed, add_count-1, entries with larger age decrement age, ex_busy=0, -> IDLE.
- ex_* hold their values outside ISSUE; only ex_b qualifies them.
- Simultaneous alloc and free in one cycle: both apply, add_count unchanged. Alloc uses the start-of-cycle free list, so the freed slot is reusable next cycle.
- Full: alloc_ready=0 and alloc_valid is ignored. Empty: FSM stays IDLE.
- Arithmetic is not performed here; the exec unit computes results and drives the CDB.

Optional Feature:
- ADD_SCHED_B2B_EN
  - Defined: in the final WAIT cycle, if another entry is eligible, the FSM goes directly to ISSUE. Back-to-back issue spacing is EX_LAT+1 cycles.
  - Undefined: one mandatory IDLE bubble, giving spacing EX_LAT+2.

Decomposition:
- Shared package tomasulo_pkg:
  - FUNC_ADD = 4'b0000, FUNC_SUB = 4'b0001.
  - Widths DATA_W and TAG_W.
  - rs_entry_t struct.
  - FSM state enum (IDLE, ISSUE, WAIT).
- One sub-module, rs_age_select: combinational oldest-eligible picker over RS_DEPTH entries that returns the index and a found flag.

Test Plan:
- Reset, then alloc add 3+5 with both operands ready (rob 2, rd 4) -> ex_b 2 cycles after the alloc edge, ex_rs1_data=3, ex_rs2_data=5, ex_rob_ind=2; add_count back to 0 after EX_LAT.
- Alloc 3 ops, each waiting on tag 5 -> alloc_ready=0 and a 4th alloc is ignored. cdb_valid with tag 5, data 9 -> all operands captured and issue order follows allocation order.
- Alloc with src1_tag=6 in the same cycle as a CDB broadcast of tag 6, data 0x11 -> entry ready; issued with ex_rs1_data=0x11.
- Older entry waiting while a younger entry is ready -> younger issues first; the older issues after its wakeup.
- Assert rst_n low during WAIT -> ex_busy=0, add_count=0, alloc_ready=1 immediately; no ex_b afterward.
- Two ready ops with EX_LAT=2 -> ex_b pulses 3 cycles apart with ADD_SCHED_B2B_EN defined, 4 cycles apart without it.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// ============================================================================
// Module   : tomasulo_pkg
// Brief    : Shared widths, function codes, RS entry layout and scheduler states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tomasulo_pkg;

    localparam int DATA_W = 8;
    localparam int TAG_W  = 3;

    localparam logic [3:0] FUNC_ADD = 4'b0000;
    localparam logic [3:0] FUNC_SUB = 4'b0001;

    typedef struct packed {
        logic              valid;
        logic [3:0]        func;
        logic [3:0]        rd;
        logic [TAG_W-1:0]  rob;
        logic              rdy1;
        logic [TAG_W-1:0]  tag1;
        logic [DATA_W-1:0] d1;
        logic              rdy2;
        logic [TAG_W-1:0]  tag2;
        logic [DATA_W-1:0] d2;
        logic [TAG_W-1:0]  age;
        logic              issued;
    } rs_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/rs_age_select.sv
// ============================================================================
// Module   : rs_age_select
// Brief    : Combinational picker returning the eligible entry with smallest age.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rs_age_select
    import tomasulo_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]       elig,
    input  logic [N*TAG_W-1:0] ages,
    output logic [TAG_W-1:0]   sel_idx,
    output logic               found
);

    logic [TAG_W-1:0] best;

    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        best    = '0;
        for (int i = 0; i < N; i++) begin
            if (elig[i] && (!found || ages[i*TAG_W +: TAG_W] < best)) begin
                found   = 1'b1;
                sel_idx = TAG_W'(i);
                best    = ages[i*TAG_W +: TAG_W];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/add_rs_sched.sv
// ============================================================================
// Module   : add_rs_sched
// Brief    : Add/sub reservation stations and issue scheduler for one exec unit.
//            ADD_SCHED_B2B_EN: issue straight from the last WAIT cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module add_rs_sched
    import tomasulo_pkg::*;
#(
    parameter int RS_DEPTH = 3,
    parameter int EX_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [3:0]        alloc_func,
    input  logic [3:0]        alloc_rd,
    input  logic [TAG_W-1:0]  alloc_rob,
    input  logic              alloc_src1_rdy,
    input  logic              alloc_src2_rdy,
    input  logic [TAG_W-1:0]  alloc_src1_tag,
    input  logic [TAG_W-1:0]  alloc_src2_tag,
    input  logic [DATA_W-1:0] alloc_src1_data,
    input  logic [DATA_W-1:0] alloc_src2_data,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              ex_b,
    output logic [TAG_W-1:0]  ex_rs_index,
    output logic [DATA_W-1:0] ex_rs1_data,
    output logic [DATA_W-1:0] ex_rs2_data,
    output logic [3:0]        ex_func,
    output logic [3:0]        ex_rd,
    output logic [TAG_W-1:0]  ex_rob_ind,
    output logic              ex_busy,
    output logic [TAG_W-1:0]  add_count
);

    localparam int LAT_W = 4;

    rs_entry_t         ent_q [RS_DEPTH];
    rs_entry_t         ent_d [RS_DEPTH];
    sched_state_e      state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [TAG_W-1:0]  count_q, count_d;
    logic              ex_b_q, ex_b_d, ex_busy_q, ex_busy_d;
    logic [TAG_W-1:0]  ex_idx_q, ex_idx_d, ex_rob_q, ex_rob_d;
    logic [DATA_W-1:0] ex_d1_q, ex_d1_d, ex_d2_q, ex_d2_d;
    logic [3:0]        ex_func_q, ex_func_d, ex_rd_q, ex_rd_d;

    logic [RS_DEPTH-1:0]       elig;
    logic [RS_DEPTH*TAG_W-1:0] ages;
    logic [TAG_W-1:0]          sel_idx, alloc_idx, freed_age;
    logic                      found, alloc_fire, free_fire;

    for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_pack
        assign elig[gi] = ent_q[gi].valid && ent_q[gi].rdy1 && ent_q[gi].rdy2 && !ent_q[gi].issued;
        assign ages[gi*TAG_W +: TAG_W] = ent_q[gi].age;
    end

    rs_age_select #(.N(RS_DEPTH)) u_sel (
        .elig    (elig),
        .ages    (ages),
        .sel_idx (sel_idx),
        .found   (found)
    );

    assign alloc_ready = (count_q < TAG_W'(RS_DEPTH));
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign free_fire   = (state_q == WAIT) && (lat_q == LAT_W'(1));

    always_comb begin
        alloc_idx = '0;
        freed_age = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!ent_q[i].valid) alloc_idx = TAG_W'(i);
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (TAG_W'(i) == ex_idx_q) freed_age = ent_q[i].age;
        end
    end

    always_comb begin
        ent_d     = ent_q;
        state_d   = state_q;
        lat_d     = lat_q;
        count_d   = count_q;
        ex_b_d    = 1'b0;
        ex_busy_d = ex_busy_q;
        ex_idx_d  = ex_idx_q;
        ex_rob_d  = ex_rob_q;
        ex_d1_d   = ex_d1_q;
        ex_d2_d   = ex_d2_q;
        ex_func_d = ex_func_q;
        ex_rd_d   = ex_rd_q;

        case (state_q)
            IDLE: begin
                if (found) state_d = ISSUE;
            end
            ISSUE: begin
                ex_b_d    = 1'b1;
                ex_busy_d = 1'b1;
                lat_d     = LAT_W'(EX_LAT);
                ex_idx_d  = sel_idx;
                state_d   = WAIT;
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (TAG_W'(i) == sel_idx) begin
                        ex_rob_d        = ent_q[i].rob;
                        ex_d1_d         = ent_q[i].d1;
                        ex_d2_d         = ent_q[i].d2;
                        ex_func_d       = ent_q[i].func;
                        ex_rd_d         = ent_q[i].rd;
                        ent_d[i].issued = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (free_fire) begin
                    ex_busy_d = 1'b0;
`ifdef ADD_SCHED_B2B_EN
                    state_d = found ? ISSUE : IDLE;
`else
                    state_d = IDLE;
`endif
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        for (int i = 0; i < RS_DEPTH; i++) begin
            if (cdb_valid && ent_q[i].valid) begin
                if (!ent_q[i].rdy1 && ent_q[i].tag1 == cdb_tag) begin
                    ent_d[i].rdy1 = 1'b1;
                    ent_d[i].d1   = cdb_data;
                end
                if (!ent_q[i].rdy2 && ent_q[i].tag2 == cdb_tag) begin
                    ent_d[i].rdy2 = 1'b1;
                    ent_d[i].d2   = cdb_data;
                end
            end
            // Retiring entry leaves; younger entries close the age gap behind it.
            if (free_fire) begin
                if (TAG_W'(i) == ex_idx_q) begin
                    ent_d[i] = '0;
                end else if (ent_q[i].valid && ent_q[i].age > freed_age) begin
                    ent_d[i].age = ent_q[i].age - TAG_W'(1);
                end
            end
            if (alloc_fire && TAG_W'(i) == alloc_idx) begin
                ent_d[i].valid  = 1'b1;
                ent_d[i].func   = alloc_func;
                ent_d[i].rd     = alloc_rd;
                ent_d[i].rob    = alloc_rob;
                ent_d[i].tag1   = alloc_src1_tag;
                ent_d[i].tag2   = alloc_src2_tag;
                ent_d[i].rdy1   = alloc_src1_rdy || (cdb_valid && cdb_tag == alloc_src1_tag);
                ent_d[i].rdy2   = alloc_src2_rdy || (cdb_valid && cdb_tag == alloc_src2_tag);
                ent_d[i].d1     = alloc_src1_rdy ? alloc_src1_data : cdb_data;
                ent_d[i].d2     = alloc_src2_rdy ? alloc_src2_data : cdb_data;
                ent_d[i].age    = free_fire ? count_q - TAG_W'(1) : count_q;
                ent_d[i].issued = 1'b0;
            end
        end

        if (alloc_fire && !free_fire) begin
            count_d = count_q + TAG_W'(1);
        end else if (!alloc_fire && free_fire) begin
            count_d = count_q - TAG_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= '0;
            state_q   <= IDLE;
            lat_q     <= '0;
            count_q   <= '0;
            ex_b_q    <= 1'b0;
            ex_busy_q <= 1'b0;
            ex_idx_q  <= '0;
            ex_rob_q  <= '0;
            ex_d1_q   <= '0;
            ex_d2_q   <= '0;
            ex_func_q <= '0;
            ex_rd_q   <= '0;
        end else begin
            ent_q     <= ent_d;
            state_q   <= state_d;
            lat_q     <= lat_d;
            count_q   <= count_d;
            ex_b_q    <= ex_b_d;
            ex_busy_q <= ex_busy_d;
            ex_idx_q  <= ex_idx_d;
            ex_rob_q  <= ex_rob_d;
            ex_d1_q   <= ex_d1_d;
            ex_d2_q   <= ex_d2_d;
            ex_func_q <= ex_func_d;
            ex_rd_q   <= ex_rd_d;
        end
    end

    assign ex_b        = ex_b_q;
    assign ex_busy     = ex_busy_q;
    assign ex_rs_index = ex_idx_q;
    assign ex_rob_ind  = ex_rob_q;
    assign ex_rs1_data = ex_d1_q;
    assign ex_rs2_data = ex_d2_q;
    assign ex_func     = ex_func_q;
    assign ex_rd       = ex_rd_q;
    assign add_count   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_add_rs_sched.sv
// ============================================================================
// Module   : tb_add_rs_sched
// Brief    : Directed and random checks of add_rs_sched against an op-queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_add_rs_sched;

    localparam int L     = 2;
    localparam int DEPTH = 3;
`ifdef ADD_SCHED_B2B_EN
    localparam int B2B = 1;
`else
    localparam int B2B = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alloc_valid = 1'b0;
    logic       alloc_ready;
    logic [3:0] alloc_func = '0, alloc_rd = '0;
    logic [2:0] alloc_rob = '0;
    logic       alloc_src1_rdy = 1'b0, alloc_src2_rdy = 1'b0;
    logic [2:0] alloc_src1_tag = '0, alloc_src2_tag = '0;
    logic [7:0] alloc_src1_data = '0, alloc_src2_data = '0;
    logic       cdb_valid = 1'b0;
    logic [2:0] cdb_tag = '0;
    logic [7:0] cdb_data = '0;
    logic       ex_b, ex_busy;
    logic [2:0] ex_rs_index, ex_rob_ind, add_count;
    logic [7:0] ex_rs1_data, ex_rs2_data;
    logic [3:0] ex_func, ex_rd;

    always #5 clk = ~clk;

    add_rs_sched #(.RS_DEPTH(DEPTH), .EX_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_func(alloc_func), .alloc_rd(alloc_rd), .alloc_rob(alloc_rob),
        .alloc_src1_rdy(alloc_src1_rdy), .alloc_src2_rdy(alloc_src2_rdy),
        .alloc_src1_tag(alloc_src1_tag), .alloc_src2_tag(alloc_src2_tag),
        .alloc_src1_data(alloc_src1_data), .alloc_src2_data(alloc_src2_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .ex_b(ex_b), .ex_rs_index(ex_rs_index),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_func(ex_func), .ex_rd(ex_rd), .ex_rob_ind(ex_rob_ind),
        .ex_busy(ex_busy), .add_count(add_count)
    );

    // Ops in allocation order: queue position is the age.
    typedef struct {
        bit [2:0] rob; bit [3:0] rd; bit [3:0] func; int slot;
        bit r1; bit [2:0] t1; bit [7:0] d1;
        bit r2; bit [2:0] t2; bit [7:0] d2;
        bit iss;
    } op_t;

    op_t mq[$];
    int  total = 0, bad = 0;
    int  cyc = 0, avail = 0, free_edge = -1, last_exb_cyc = -1;
    bit  pend = 0, busy = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        pend = 0; busy = 0; avail = 0; free_edge = -1;
    endtask

    task automatic step();
        int pick, sz0, slot, fi;
        bit exp_b, dec;
        bit [DEPTH-1:0] used;
        op_t ex_op, n;
        pick = -1;
        foreach (mq[i]) if (pick < 0 && !mq[i].iss && mq[i].r1 && mq[i].r2) pick = i;
        exp_b = pend;
        dec   = !pend && (cyc >= avail) && (pick >= 0);
        if (exp_b) ex_op = mq[pick];
        sz0 = mq.size();
        used = '0;
        foreach (mq[i]) used[mq[i].slot] = 1'b1;
        slot = -1;
        for (int s = DEPTH - 1; s >= 0; s--) if (!used[s]) slot = s;
        n.rob = alloc_rob; n.rd = alloc_rd; n.func = alloc_func; n.slot = slot; n.iss = 0;
        n.t1 = alloc_src1_tag; n.t2 = alloc_src2_tag;
        n.r1 = alloc_src1_rdy || (cdb_valid && cdb_tag == alloc_src1_tag);
        n.r2 = alloc_src2_rdy || (cdb_valid && cdb_tag == alloc_src2_tag);
        n.d1 = alloc_src1_rdy ? alloc_src1_data : cdb_data;
        n.d2 = alloc_src2_rdy ? alloc_src2_data : cdb_data;

        @(posedge clk); #1;

        if (exp_b) begin
            mq[pick].iss = 1;
            free_edge    = cyc + L;
            avail        = cyc + L + (B2B ? 0 : 1);
            pend = 0; busy = 1; last_exb_cyc = cyc;
        end
        if (dec) pend = 1;
        if (cyc == free_edge) begin
            fi = -1;
            foreach (mq[i]) if (mq[i].iss) fi = i;
            if (fi >= 0) mq.delete(fi);
            busy = 0;
        end
        if (cdb_valid) begin
            foreach (mq[i]) begin
                if (!mq[i].r1 && mq[i].t1 == cdb_tag) begin mq[i].r1 = 1; mq[i].d1 = cdb_data; end
                if (!mq[i].r2 && mq[i].t2 == cdb_tag) begin mq[i].r2 = 1; mq[i].d2 = cdb_data; end
            end
        end
        if (alloc_valid && sz0 < DEPTH) mq.push_back(n);

        chk("ex_b", ex_b, exp_b);
        chk("add_count", add_count, mq.size());
        chk("alloc_ready", alloc_ready, mq.size() < DEPTH);
        chk("ex_busy", ex_busy, busy);
        if (exp_b) begin
            chk("ex_rob_ind", ex_rob_ind, ex_op.rob);
            chk("ex_rd", ex_rd, ex_op.rd);
            chk("ex_func", ex_func, ex_op.func);
            chk("ex_rs1_data", ex_rs1_data, ex_op.d1);
            chk("ex_rs2_data", ex_rs2_data, ex_op.d2);
            chk("ex_rs_index", ex_rs_index, ex_op.slot);
        end
        cyc++;
    endtask

    task automatic set_alloc(input bit v, input bit [3:0] f, input bit [3:0] rd, input bit [2:0] rob,
                             input bit r1, input bit [2:0] t1, input bit [7:0] d1,
                             input bit r2, input bit [2:0] t2, input bit [7:0] d2);
        alloc_valid = v; alloc_func = f; alloc_rd = rd; alloc_rob = rob;
        alloc_src1_rdy = r1; alloc_src1_tag = t1; alloc_src1_data = d1;
        alloc_src2_rdy = r2; alloc_src2_tag = t2; alloc_src2_data = d2;
    endtask

    task automatic wait_exb(input string tag, input int max);
        bit ok = 0;
        for (int k = 0; k < max && !ok; k++) begin
            step();
            if (ex_b === 1'b1) ok = 1;
        end
        chk({"wait_", tag}, ok, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && mq.size() != 0; k++) step();
        chk("drain_empty", add_count, 0);
    endtask

    initial begin
        bit seen;
        int c0;
        // Reset values while reset is held
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_b", ex_b, 0);
        chk("rst_ex_busy", ex_busy, 0);
        chk("rst_add_count", add_count, 0);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_ex_rob_ind", ex_rob_ind, 0);
        @(negedge clk) rst_n = 1'b1;
        model_clear();

        // 3 + 5, ready at dispatch
        set_alloc(1, 4'b0000, 4'd4, 3'd2, 1, 3'd0, 8'd3, 1, 3'd0, 8'd5);
        step();
        alloc_valid = 0;
        step();
        step();
        chk("t1_ex_b", ex_b, 1);
        chk("t1_rs1", ex_rs1_data, 8'd3);
        chk("t1_rs2", ex_rs2_data, 8'd5);
        chk("t1_rob", ex_rob_ind, 3'd2);
        repeat (L) step();
        chk("t1_count", add_count, 0);

        // Fill with ops waiting on tag 5, then wake them all at once
        set_alloc(1, 4'b0001, 4'd1, 3'd1, 0, 3'd5, 8'd0, 0, 3'd5, 8'd0); step();
        set_alloc(1, 4'b0000, 4'd2, 3'd3, 0, 3'd5, 8'd0, 1, 3'd0, 8'd7); step();
        set_alloc(1, 4'b0001, 4'd3, 3'd6, 1, 3'd0, 8'd2, 0, 3'd5, 8'd0); step();
        chk("t2_full_ready", alloc_ready, 0);
        set_alloc(1, 4'b0000, 4'd9, 3'd7, 1, 3'd0, 8'd1, 1, 3'd0, 8'd1); step();
        chk("t2_full_count", add_count, 3);
        alloc_valid = 0;
        cdb_valid = 1; cdb_tag = 3'd5; cdb_data = 8'd9;
        step();
        cdb_valid = 0;
        wait_exb("t2a", 10); chk("t2_order0", ex_rob_ind, 3'd1); chk("t2_d0", ex_rs1_data, 8'd9);
        wait_exb("t2b", 10); chk("t2_order1", ex_rob_ind, 3'd3);
        wait_exb("t2c", 10); chk("t2_order2", ex_rob_ind, 3'd6); chk("t2_d2", ex_rs2_data, 8'd9);
        drain();

        // Operand captured from the CDB in the allocation cycle
        set_alloc(1, 4'b0000, 4'd5, 3'd4, 0, 3'd6, 8'd0, 1, 3'd0, 8'h22);
        cdb_valid = 1; cdb_tag = 3'd6; cdb_data = 8'h11;
        step();
        alloc_valid = 0; cdb_valid = 0;
        wait_exb("t3", 10);
        chk("t3_rs1", ex_rs1_data, 8'h11);
        drain();

        // Younger ready op overtakes older waiting op
        set_alloc(1, 4'b0001, 4'd6, 3'd1, 0, 3'd7, 8'd0, 1, 3'd0, 8'h33); step();
        set_alloc(1, 4'b0000, 4'd7, 3'd2, 1, 3'd0, 8'h44, 1, 3'd0, 8'h55); step();
        alloc_valid = 0;
        wait_exb("t4a", 10);
        chk("t4_young_first", ex_rob_ind, 3'd2);
        cdb_valid = 1; cdb_tag = 3'd7; cdb_data = 8'h66;
        step();
        cdb_valid = 0;
        wait_exb("t4b", 10);
        chk("t4_old_second", ex_rob_ind, 3'd1);
        chk("t4_old_rs1", ex_rs1_data, 8'h66);
        drain();

        // Issue spacing for back-to-back ready ops
        set_alloc(1, 4'b0000, 4'd1, 3'd3, 1, 3'd0, 8'd1, 1, 3'd0, 8'd2); step();
        set_alloc(1, 4'b0001, 4'd2, 3'd5, 1, 3'd0, 8'd3, 1, 3'd0, 8'd4); step();
        alloc_valid = 0;
        wait_exb("t6a", 10);
        c0 = last_exb_cyc;
        wait_exb("t6b", 10);
        chk("t6_spacing", last_exb_cyc - c0, L + (B2B ? 1 : 2));
        drain();

        // Reset during WAIT
        set_alloc(1, 4'b0000, 4'd3, 3'd4, 1, 3'd0, 8'd8, 1, 3'd0, 8'd9); step();
        set_alloc(1, 4'b0000, 4'd4, 3'd5, 1, 3'd0, 8'd1, 1, 3'd0, 8'd1); step();
        alloc_valid = 0;
        wait_exb("t5", 10);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy", ex_busy, 0);
        chk("t5_count", add_count, 0);
        chk("t5_ready", alloc_ready, 1);
        model_clear();
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (8) begin step(); if (ex_b === 1'b1) seen = 1; end
        chk("t5_no_exb", seen, 0);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            set_alloc($urandom_range(0, 1), 4'($urandom_range(0, 1)), 4'($urandom), 3'($urandom),
                      ($urandom_range(0, 2) != 0), 3'($urandom), 8'($urandom),
                      ($urandom_range(0, 2) != 0), 3'($urandom), 8'($urandom));
            cdb_valid = ($urandom_range(0, 3) == 0);
            cdb_tag   = 3'($urandom);
            cdb_data  = 8'($urandom);
            step();
        end
        alloc_valid = 0; cdb_valid = 0;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
